// File: rtl/pc_sequencer_if.sv
// Fetch/execute handshake and redirect bus between the PC sequencer and the
// instruction memory / execute stage of the multicycle core.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        jmp;
  logic [25:0] jmp_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        eret;
  logic [31:0] epc_in;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic [31:0] epc_out;
  logic        exc_taken;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, link_addr,
           epc_out, exc_taken, retired,
    input  imem_ack, imem_rdata, exec_done, br_taken, br_offset, jmp,
           jmp_index, jr, jr_target, eret, epc_in, exc_req
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, link_addr,
           epc_out, exc_taken, retired,
    output imem_ack, imem_rdata, exec_done, br_taken, br_offset, jmp,
           jmp_index, jr, jr_target, eret, epc_in, exc_req
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC, sequences instruction fetch and
// execute for the multicycle core, handles exception/ERET redirects and
// counts retired instructions. PCs live in the rebased (TEXT_BASE = 0) space.
module pc_sequencer #(
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] epc_q;
  logic [31:0] retired_q;
  logic        instr_valid_q;
  logic        exc_taken_q;
  logic        exc_pend_q;

  logic        imem_req;
  logic        fetch_done;
  logic        retire_evt;
  logic        exc_apply;
  logic [31:0] pc4;
  logic [31:0] next_pc;

  // Non-exception next PC; priority eret > jr > jmp > branch > sequential.
  // Jump indices are absolute text addresses and are rebased by TEXT_BASE.
  function automatic logic [31:0] redirect_pc(
    input logic [31:0] pc_plus4,
    input logic        eret,
    input logic [31:0] epc,
    input logic        jr,
    input logic [31:0] jr_target,
    input logic        jmp,
    input logic [25:0] jmp_index,
    input logic        br_taken,
    input logic [15:0] br_offset
  );
    logic [25:0]        idx_rebased;
    logic signed [31:0] br_disp;
    idx_rebased = jmp_index - TEXT_BASE[27:2];
    br_disp     = {{14{br_offset[15]}}, br_offset, 2'b00};
    if (eret)          redirect_pc = epc;
    else if (jr)       redirect_pc = jr_target;
    else if (jmp)      redirect_pc = {pc_plus4[31:28], idx_rebased, 2'b00};
    else if (br_taken) redirect_pc = pc_plus4 + br_disp;
    else               redirect_pc = pc_plus4;
  endfunction

  assign pc4     = pc_q + 32'd4;
  assign next_pc = redirect_pc(pc4, bus.eret, bus.epc_in, bus.jr, bus.jr_target,
                               bus.jmp, bus.jmp_index, bus.br_taken, bus.br_offset);

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.link_addr   = pc4;
  assign bus.epc_out     = epc_q;
  assign bus.exc_taken   = exc_taken_q;
  assign bus.retired     = retired_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // FSM next state and per-cycle events; an exception (new or pending) at
  // exec_done replaces retirement of the instruction.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    fetch_done = 1'b0;
    retire_evt = 1'b0;
    exc_apply  = 1'b0;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          fetch_done = 1'b1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        if (bus.exec_done) begin
          state_nxt = FETCH;
          if (bus.exc_req || exc_pend_q) exc_apply  = 1'b1;
          else                           retire_evt = 1'b1;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // PC, EPC and the pending-exception flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= TEXT_BASE - TEXT_BASE;
      epc_q      <= 32'd0;
      exc_pend_q <= 1'b0;
    end else if (exc_apply) begin
      epc_q      <= pc_q;
      pc_q       <= EXC_VECTOR;
      exc_pend_q <= 1'b0;
    end else if (retire_evt) begin
      pc_q       <= next_pc;
    end else if (bus.exc_req) begin
      exc_pend_q <= 1'b1;
    end
  end

  // Latched instruction word and its valid flag, held through EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
    end else if (fetch_done) begin
      instr_q       <= bus.imem_rdata;
      instr_valid_q <= 1'b1;
    end else if (retire_evt || exc_apply) begin
      instr_valid_q <= 1'b0;
    end
  end

  // One-cycle pulse following an applied exception redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) exc_taken_q <= 1'b0;
    else        exc_taken_q <= exc_apply;
  end

  // Retired-instruction counter, wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n)          retired_q <= 32'd0;
    else if (retire_evt) retired_q <= retired_q + 32'd1;
  end

endmodule
